// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU and its built-in self-test controller:
//   - alu_op_e      : ALU opcode encoding (ADD=000 ... PASS=111)
//   - bist_state_e  : BIST controller states
//   - MISR width, default polynomial and seed, vector counter width
//   - misr_step()   : one signature compaction step
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SHL  = 3'b010,
        ALU_SHR  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_NOT  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        BIST_IDLE = 2'd0,
        BIST_RUN  = 2'd1,
        BIST_DONE = 2'd2
    } bist_state_e;

    localparam int              MISR_W        = 16;
    localparam int              VEC_W         = 19;
    localparam logic [MISR_W-1:0] MISR_POLY_DEF = 16'h1021;
    localparam logic [MISR_W-1:0] MISR_SEED_DEF = 16'hFFFF;

    // Shift left, apply feedback when the bit shifted out is set, then
    // fold in the parallel data word.
    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] sig,
        input logic [MISR_W-1:0] data,
        input logic [MISR_W-1:0] poly
    );
        logic [MISR_W-1:0] fb;
        fb = sig[MISR_W-1] ? poly : '0;
        return ({sig[MISR_W-2:0], 1'b0} ^ fb) ^ data;
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// -----------------------------------------------------------------------------
// alu_bist_misr
// 16-bit multiple-input signature register.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_n   : asynchronous active-low reset, clears the signature to 0
//   load_i  : load the seed value (has priority over fold_i)
//   fold_i  : compact data_i into the signature
//   data_i  : parallel data word
//   sig_o   : current signature
// -----------------------------------------------------------------------------
module alu_bist_misr
    import alu_pkg::*;
#(
    parameter logic [MISR_W-1:0] POLY = MISR_POLY_DEF,
    parameter logic [MISR_W-1:0] SEED = MISR_SEED_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              fold_i,
    input  logic [MISR_W-1:0] data_i,
    output logic [MISR_W-1:0] sig_o
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (fold_i) begin
            sig_d = misr_step(sig_q, data_i, POLY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/alu_bist.sv
// -----------------------------------------------------------------------------
// alu_bist
// Built-in self-test controller for the 8-bit ALU. Sweeps every {a, b, op}
// vector (op innermost, then b, then a), one per clock, folds each response
// into a MISR and compares the final signature with GOLDEN_SIG.
// Ports:
//   clk_i, rst_n        : clock, asynchronous active-low reset
//   start_i             : start request (level-sampled in IDLE/DONE)
//   a_o, b_o, op_o      : ALU stimulus, straight from the vector register
//   result_i, carry_i, negative_i, zero_i, overflow_i : ALU response
//   busy_o              : sweep in progress
//   done_o              : sweep complete, held until next start or reset
//   pass_o              : signature matches GOLDEN_SIG (valid with done_o)
//   signature_o         : current MISR value
// -----------------------------------------------------------------------------
module alu_bist
    import alu_pkg::*;
#(
    parameter logic [VEC_W-1:0]  VEC_LAST   = 19'h7FFFF,
    parameter logic [MISR_W-1:0] MISR_POLY  = MISR_POLY_DEF,
    parameter logic [MISR_W-1:0] MISR_SEED  = MISR_SEED_DEF,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              start_i,
    output logic [7:0]        a_o,
    output logic [7:0]        b_o,
    output logic [2:0]        op_o,
    input  logic [7:0]        result_i,
    input  logic              carry_i,
    input  logic              negative_i,
    input  logic              zero_i,
    input  logic              overflow_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [MISR_W-1:0] signature_o
);

    bist_state_e       state_q;
    bist_state_e       state_d;
    logic [VEC_W-1:0]  vec_q;
    logic [VEC_W-1:0]  vec_d;
    logic              load_seed;
    logic              fold;
    logic [MISR_W-1:0] misr_data;

    // State and vector registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BIST_IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    // Next state. The counter only wraps on the RUN->DONE transition, so
    // DONE always holds vec at 0 and a restart begins from vector 0.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            BIST_IDLE, BIST_DONE: begin
                if (start_i) begin
                    state_d = BIST_RUN;
                    vec_d   = '0;
                end
            end
            BIST_RUN: begin
                if (vec_q == VEC_LAST) begin
                    state_d = BIST_DONE;
                    vec_d   = '0;
                end else begin
                    vec_d = vec_q + VEC_W'(1);
                end
            end
            default: begin
                state_d = BIST_IDLE;
                vec_d   = '0;
            end
        endcase
    end

    // Outputs and MISR controls. The response folded at each RUN edge is
    // the one to the vector driven during the cycle ending at that edge.
    always_comb begin
        busy_o    = 1'b0;
        done_o    = 1'b0;
        load_seed = 1'b0;
        fold      = 1'b0;
        case (state_q)
            BIST_IDLE: load_seed = start_i;
            BIST_RUN: begin
                busy_o = 1'b1;
                fold   = 1'b1;
            end
            BIST_DONE: begin
                done_o    = 1'b1;
                load_seed = start_i;
            end
            default: ;
        endcase
    end

    assign a_o  = vec_q[18:11];
    assign b_o  = vec_q[10:3];
    assign op_o = vec_q[2:0];

    assign misr_data = {4'b0000, carry_i, negative_i, zero_i, overflow_i, result_i};

    alu_bist_misr #(
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .load_i (load_seed),
        .fold_i (fold),
        .data_i (misr_data),
        .sig_o  (signature_o)
    );

    assign pass_o = done_o && (signature_o == GOLDEN_SIG);

endmodule
